// File: rtl/pc_pkg.sv
// Shared definitions for the program counter: default sizing and the
// next-PC source selection enum.
package pc_pkg;

  localparam int PC_W_DEFAULT     = 10;
  localparam int RESET_PC_DEFAULT = 0;

  // Source of the next PC value.
  typedef enum logic [1:0] {
    PC_SEL_HOLD   = 2'd0,
    PC_SEL_JUMP   = 2'd1,
    PC_SEL_BRANCH = 2'd2,
    PC_SEL_INC    = 2'd3
  } pc_sel_t;

endpackage : pc_pkg

// File: rtl/pc_next_logic.sv
// Combinational next-PC computation. Decodes the control inputs into a
// pc_sel_t (hold > jump > branch > increment) and produces the candidate
// next PC. Reset is handled by the register stage in the top level.
module pc_next_logic
  import pc_pkg::*;
#(
  parameter int PC_W = PC_W_DEFAULT
) (
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] target,
  input  logic            halt,
  input  logic            jump_en,
  input  logic            branch_en,
  output logic [PC_W-1:0] pc_next
);

  pc_sel_t sel_s;

  // Priority decode of the control inputs; halt beats jump beats branch.
  always_comb begin
    sel_s = PC_SEL_INC;
    if (halt) begin
      sel_s = PC_SEL_HOLD;
    end else if (jump_en) begin
      sel_s = PC_SEL_JUMP;
    end else if (branch_en) begin
      sel_s = PC_SEL_BRANCH;
    end else begin
      sel_s = PC_SEL_INC;
    end
  end

  // Next-PC datapath. Branch adds the two's-complement offset; the plain
  // modulo-2^PC_W add gives the signed result because widths match.
  always_comb begin
    pc_next = pc;
    case (sel_s)
      PC_SEL_HOLD:   pc_next = pc;
      PC_SEL_JUMP:   pc_next = target;
      PC_SEL_BRANCH: pc_next = pc + target;
      PC_SEL_INC:    pc_next = pc + {{(PC_W-1){1'b0}}, 1'b1};
      default:       pc_next = pc;
    endcase
  end

endmodule : pc_next_logic

// File: rtl/program_counter.sv
// Program counter register with synchronous active-low reset (init).
// Optional feature: define PC_STICKY_HALT_EN to make a sampled halt latch
// an internal halted flag that freezes the PC until the next reset.
// Without it, the PC freezes only in cycles where halt is high.
module program_counter
  import pc_pkg::*;
#(
  parameter int PC_W     = PC_W_DEFAULT,
  parameter int RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            CLK,
  input  logic            init,
  input  logic            jump_en,
  input  logic            branch_en,
  input  logic            halt,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] PC
);

  localparam logic [PC_W-1:0] RESET_PC_V = PC_W'(RESET_PC);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] pc_next_s;
  logic            halt_eff_s;

`ifdef PC_STICKY_HALT_EN
  logic halted_q;
  logic halted_d;

  // Once halt is sampled the flag stays set; it also holds the PC meanwhile.
  always_comb begin
    halted_d   = halted_q | halt;
    halt_eff_s = halted_q | halt;
  end

  // Halted flag register; reset clears it.
  always_ff @(posedge CLK) begin
    if (!init) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end
`else
  assign halt_eff_s = halt;
`endif

  pc_next_logic #(
    .PC_W (PC_W)
  ) u_pc_next_logic (
    .pc        (pc_q),
    .target    (target),
    .halt      (halt_eff_s),
    .jump_en   (jump_en),
    .branch_en (branch_en),
    .pc_next   (pc_next_s)
  );

  // Register input comes straight from the next-PC logic.
  always_comb begin
    pc_d = pc_next_s;
  end

  // PC register; reset overrides every request.
  always_ff @(posedge CLK) begin
    if (!init) begin
      pc_q <= RESET_PC_V;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign PC = pc_q;

endmodule : program_counter

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter (PC_W=10, RESET_PC=0).
// A reference model predicts each PC value when stimulus is driven; the
// prediction is queued and compared once the clock edge has produced it.
// Directed scenarios are additionally checked against fixed constants.
module tb_program_counter;

  localparam int W = 10;

  logic         CLK = 1'b0;
  logic         init = 1'b1;
  logic         jump_en = 1'b0;
  logic         branch_en = 1'b0;
  logic         halt = 1'b0;
  logic [W-1:0] target = '0;
  logic [W-1:0] PC;

  int n_checks = 0;
  int n_fails  = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_pc = '0;
  logic         m_halted = 1'b0;

  program_counter #(.PC_W(W), .RESET_PC(0)) dut (
    .CLK       (CLK),
    .init      (init),
    .jump_en   (jump_en),
    .branch_en (branch_en),
    .halt      (halt),
    .target    (target),
    .PC        (PC)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, predict the result, then compare after the edge.
  task automatic cycle(input logic i_init, input logic i_halt, input logic i_jump,
                       input logic i_branch, input logic [W-1:0] i_target);
    logic hold;
    @(negedge CLK);
    init = i_init; halt = i_halt; jump_en = i_jump; branch_en = i_branch; target = i_target;
    if (!i_init) begin
      m_pc = '0;
      m_halted = 1'b0;
    end else begin
`ifdef PC_STICKY_HALT_EN
      hold = i_halt | m_halted;
      m_halted = m_halted | i_halt;
`else
      hold = i_halt;
`endif
      if (hold)          m_pc = m_pc;
      else if (i_jump)   m_pc = i_target;
      else if (i_branch) m_pc = m_pc + i_target;
      else               m_pc = m_pc + 10'd1;
    end
    exp_q.push_back(m_pc);
    @(posedge CLK);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL scoreboard: empty queue");
    end else begin
      check_eq("model", PC, exp_q.pop_front());
    end
  endtask

  task automatic idle();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
  endtask

  initial begin
    // Reset from arbitrary state, then free-running increments.
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 10'd77);
    check_eq("reset", PC, 10'd0);
    idle(); check_eq("inc1", PC, 10'd1);
    idle(); check_eq("inc2", PC, 10'd2);
    idle(); check_eq("inc3", PC, 10'd3);

    // Absolute jumps.
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 10'd5);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 10'd4); check_eq("jump4", PC, 10'd4);
    idle();                               check_eq("after_jump", PC, 10'd5);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 10'd3); check_eq("jump3", PC, 10'd3);

    // Relative branches, held two cycles, then a negative offset.
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 10'd10);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 10'd3);     check_eq("branch_13", PC, 10'd13);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 10'd3);     check_eq("branch_16", PC, 10'd16);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 10'h3FE);   check_eq("branch_neg", PC, 10'd14);

    // Halt for 5 cycles with jump pulses in between.
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 10'd20);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, (i % 2) == 1, 1'b0, 10'd99);
      check_eq("halt_hold", PC, 10'd20);
    end
`ifdef PC_STICKY_HALT_EN
    idle(); check_eq("sticky_hold", PC, 10'd20);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 10'd50); check_eq("sticky_jump_ignored", PC, 10'd20);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 10'd0);  check_eq("sticky_reset", PC, 10'd0);
    idle(); check_eq("sticky_resume", PC, 10'd1);
`else
    idle(); check_eq("halt_release", PC, 10'd21);
`endif

    // Wrap-around and jump/branch collision.
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 10'd1023);
    idle();                               check_eq("wrap", PC, 10'd0);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 10'd7); check_eq("jump_beats_branch", PC, 10'd7);

    // Reset beats jump; increments resume right after.
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 10'd9); check_eq("reset_beats_jump", PC, 10'd0);
    idle();                               check_eq("post_reset_inc", PC, 10'd1);

    // Randomised traffic against the model.
    for (int i = 0; i < 80; i++) begin
      cycle($urandom_range(15, 0) != 0, $urandom_range(7, 0) == 0,
            $urandom_range(3, 0) == 0, $urandom_range(2, 0) == 0,
            W'($urandom_range(1023, 0)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Absolute time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule : tb_program_counter

// File: doc/program_counter.md
PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
- REQ-001 Parameter PC_W, default 10, width of the program counter and target bus.
- REQ-002 Parameter RESET_PC, default 0, PC value loaded on reset.
- REQ-003 CLK  input  1  single clock; all state updates on rising edge.
- REQ-004 init  input  1  reset, synchronous, active-low (0 = reset on the next rising CLK edge).
- REQ-005 jump_en  input  1  absolute jump request.
- REQ-006 branch_en  input  1  PC-relative branch request.
- REQ-007 halt  input  1  stop advancing the PC.
- REQ-008 target  input  PC_W  jump address (absolute) or branch offset (two's complement).
- REQ-009 PC  output  PC_W  current program counter, driven directly from a register.

Function
- REQ-010 PC SHALL update only on the rising CLK edge; no combinational path from any input to PC.
- REQ-011 Next-PC priority SHALL be: reset > halt > jump_en > branch_en > increment.
- REQ-012 halt=1 SHALL hold PC unchanged, regardless of jump_en and branch_en.
- REQ-013 jump_en=1 (no halt) SHALL load PC <= target.
- REQ-014 branch_en=1 (no halt, no jump) SHALL load PC <= PC + target, with target treated as signed; result modulo 2^PC_W.
- REQ-015 Otherwise, PC SHALL load PC + 1 modulo 2^PC_W, so 2^PC_W-1 wraps to 0.
- REQ-016 jump_en and branch_en asserted together SHALL behave as jump only.
- REQ-017 A request held for N cycles SHALL act N times (e.g. branch held 2 cycles adds target twice).
- REQ-018 Latency SHALL be one cycle: the new PC is visible in the cycle after the edge that sampled the request.

Reset
- REQ-019 On a rising CLK edge with init=0, PC SHALL become RESET_PC, overriding halt, jump_en and branch_en.
- REQ-020 Reset asserted mid-operation SHALL take effect at the next edge; PC+1 increments resume on the first edge after init returns to 1.
- REQ-021 Reset SHALL clear any internal halt state.

Configuration
- REQ-022 Macro PC_STICKY_HALT_EN defined: a halt=1 sample SHALL set an internal halted flag that freezes PC until reset, even after halt returns to 0.
- REQ-023 Macro PC_STICKY_HALT_EN undefined: PC SHALL freeze only in cycles where halt=1, with no internal flag.

Structure
- REQ-024 Package pc_pkg SHALL hold PC_W_DEFAULT, RESET_PC_DEFAULT and typedef enum pc_sel_t {PC_SEL_HOLD, PC_SEL_JUMP, PC_SEL_BRANCH, PC_SEL_INC}.
- REQ-025 Sub-module pc_next_logic SHALL be purely combinational: it decodes the control inputs to pc_sel_t and computes the next PC. The top level holds only the PC register and the optional halted flag.

Verification
- REQ-026 init=0 for one edge with PC arbitrary -> PC=0. Then init=1 with no requests -> PC 1, 2, 3 on successive edges.
- REQ-027 PC=5, jump_en=1, target=4 for one cycle -> PC=4, then 5. Then jump_en=1, target=3 -> PC=3.
- REQ-028 PC=10, branch_en=1, target=3 for two cycles -> PC 13, 16. Then target=10'h3FE (-2) for one cycle -> PC=14.
- REQ-029 PC=20, halt=1 for 5 cycles with jump_en=1 pulsed -> PC stays 20.
  - Without the macro, releasing halt -> PC 21.
  - With the macro, PC stays 20 until init=0.
- REQ-030 Wrap and collision checks:
  - PC=1023, no requests -> PC=0.
  - jump_en=1 and branch_en=1 together, target=7 -> PC=7.
  - init=0 together with jump_en=1 -> PC=0.
